// File: rtl/mmul_pkg.sv
// Shared types and constants for the mmul_seq sequencer: state encoding,
// datapath widths and default timing parameters.
package mmul_pkg;

  localparam int X_W  = 8;   // X-vector byte width
  localparam int R_W  = 9;   // SRAM result word width
  localparam int WD_W = 10;  // watchdog counter width

  localparam int RD_WORDS_DEF  = 16;
  localparam int WB_LAT_DEF    = 2;
  localparam int TO_CYCLES_DEF = 1023;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_READ    = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERR     = 3'd6
  } state_t;

endpackage

// File: rtl/mmul_watchdog.sv
// Wait-state watchdog for mmul_seq: counts enabled cycles since the last
// clear and flags expire on the cycle the count would reach LIMIT.
module mmul_watchdog
  import mmul_pkg::*;
#(
  parameter logic [WD_W-1:0] LIMIT = WD_W'(TO_CYCLES_DEF)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [WD_W-1:0] cnt;

  assign expire = enable & ~clear & (cnt == LIMIT - WD_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear | expire) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + WD_W'(1);
    end
  end

endmodule

// File: rtl/mmul_seq.sv
// Matrix-multiply run sequencer: loads the X vector, runs the ALU, waits out
// write-back, then streams RD_WORDS results from SRAM. All outputs registered.
// Optional watchdog with ERR state: define MMUL_SEQ_WATCHDOG_EN.
module mmul_seq
  import mmul_pkg::*;
#(
  parameter int RD_WORDS  = RD_WORDS_DEF,
  parameter int WB_LAT    = WB_LAT_DEF,
  parameter int TO_CYCLES = TO_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic           x_valid_in,
  input  logic [X_W-1:0] x_data_in,
  output logic           x_ready_out,
  output logic           input_load_en,
  output logic           valid_input,
  output logic [X_W-1:0] X_load,
  input  logic           xload_done,
  input  logic           ALU_done,
  output logic           ALU_en,
  output logic           cs_n,
  input  logic           ry,
  input  logic [R_W-1:0] read_data,
  output logic           rd_valid,
  output logic [R_W-1:0] rd_data,
  output logic           busy,
  output logic           done,
  output logic           err_timeout
);

  localparam int DRAIN_W = (WB_LAT > 1) ? $clog2(WB_LAT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((WB_LAT > 0) ? WB_LAT - 1 : 0);
  localparam logic [4:0] BEAT_LAST = 5'(RD_WORDS - 1);
  localparam logic [WD_W-1:0] TO_LIMIT = WD_W'(TO_CYCLES);

  state_t state, state_base, state_nx;
  logic [4:0] beat_cnt, beat_base, beat_nx;
  logic [DRAIN_W-1:0] drain_cnt, drain_base, drain_nx;
  logic beat, accept, wd_expire;

  assign beat   = (state == ST_READ) & ry;
  assign accept = x_valid_in & x_ready_out;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_base = state;
    beat_base  = beat_cnt;
    drain_base = drain_cnt;
    case (state)
      ST_IDLE:    if (start) state_base = ST_LOAD;
      ST_LOAD:    if (xload_done) state_base = ST_COMPUTE;
      ST_COMPUTE: begin
        if (ALU_done) begin
          state_base = (WB_LAT == 0) ? ST_READ : ST_DRAIN;
          drain_base = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_base = ST_READ;
          drain_base = '0;
        end else begin
          drain_base = drain_cnt + DRAIN_W'(1);
        end
      end
      ST_READ: begin
        if (ry) begin
          if (beat_cnt == BEAT_LAST) begin
            state_base = ST_DONE;
            beat_base  = '0;
          end else begin
            beat_base = beat_cnt + 5'd1;
          end
        end
      end
      ST_DONE:    state_base = ST_IDLE;
      ST_ERR:     if (start) state_base = ST_LOAD;
      default:    state_base = ST_IDLE;
    endcase
    // abort outranks every other event in the same cycle
    if (abort) begin
      state_base = ST_IDLE;
      beat_base  = '0;
      drain_base = '0;
    end
  end

`ifdef MMUL_SEQ_WATCHDOG_EN
  logic wd_clear, wd_enable;

  assign wd_enable = (state == ST_LOAD) | (state == ST_COMPUTE) | (state == ST_READ);
  assign wd_clear  = (state_base != state) | beat;

  mmul_watchdog #(.LIMIT(TO_LIMIT)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) err_timeout <= 1'b0;
    else     err_timeout <= (state_nx == ST_ERR);
  end
`else
  logic unused_to;

  // TO_CYCLES only matters when the watchdog is built.
  assign unused_to   = ^TO_LIMIT;
  assign wd_expire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_nx = state_base;
    beat_nx  = beat_base;
    drain_nx = drain_base;
    if (wd_expire) begin
      state_nx = ST_ERR;
      beat_nx  = '0;
      drain_nx = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      beat_cnt      <= '0;
      drain_cnt     <= '0;
      x_ready_out   <= 1'b0;
      input_load_en <= 1'b0;
      valid_input   <= 1'b0;
      X_load        <= '0;
      ALU_en        <= 1'b0;
      cs_n          <= 1'b1;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nx;
      beat_cnt      <= beat_nx;
      drain_cnt     <= drain_nx;
      x_ready_out   <= (state_nx == ST_LOAD);
      input_load_en <= (state_nx == ST_LOAD);
      valid_input   <= accept & ~abort & ~wd_expire;
      if (accept & ~abort & ~wd_expire) X_load <= x_data_in;
      ALU_en        <= (state_nx == ST_COMPUTE);
      cs_n          <= (state_nx != ST_READ);
      rd_valid      <= beat & ~abort;
      if (beat & ~abort) rd_data <= read_data;
      busy          <= (state_nx != ST_IDLE) && (state_nx != ST_ERR);
      done          <= (state_nx == ST_DONE);
    end
  end

endmodule

// File: tb/tb_mmul_seq.sv
// Self-checking bench for mmul_seq: random X bytes and SRAM words go into
// expectation queues; a negedge monitor pops and compares on valid strobes.
module tb_mmul_seq;

  localparam int RD_WORDS  = 16;
  localparam int WB_LAT    = 2;
  localparam int TO_CYCLES = 1023;

  logic       clk = 1'b0;
  logic       rst, start, abort, x_valid_in, xload_done, ALU_done, ry;
  logic [7:0] x_data_in;
  logic [8:0] read_data;
  logic       x_ready_out, input_load_en, valid_input, ALU_en, cs_n;
  logic       rd_valid, busy, done, err_timeout;
  logic [7:0] X_load;
  logic [8:0] rd_data;

  mmul_seq #(.RD_WORDS(RD_WORDS), .WB_LAT(WB_LAT), .TO_CYCLES(TO_CYCLES)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .x_valid_in(x_valid_in), .x_data_in(x_data_in), .x_ready_out(x_ready_out),
    .input_load_en(input_load_en), .valid_input(valid_input), .X_load(X_load),
    .xload_done(xload_done), .ALU_done(ALU_done), .ALU_en(ALU_en),
    .cs_n(cs_n), .ry(ry), .read_data(read_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_xin = 0;
  int n_rd  = 0;
  int n_done = 0;
  logic [7:0] exp_x[$];
  logic [8:0] exp_rd[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (valid_input) begin
      n_xin++;
      if (exp_x.size() == 0) begin
        total++; bad++;
        $display("FAIL x_extra: valid_input with X_load=%0h but nothing expected", X_load);
      end else begin
        check("x_load", 32'(X_load), 32'(exp_x.pop_front()));
      end
    end
    if (rd_valid) begin
      n_rd++;
      if (exp_rd.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_extra: rd_valid with rd_data=%0h but nothing expected", rd_data);
      end else begin
        check("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
      end
    end
    if (done) n_done++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("ready_in_load", x_ready_out, 1'b1);
    check("load_en_in_load", input_load_en, 1'b1);
  endtask

  task automatic load_x(input bit fixed);
    int sent = 0;
    int guard = 0;
    int n0 = n_xin;
    logic v;
    logic [7:0] d;
    while (sent < 4 && guard < 60) begin
      v = fixed ? 1'b1 : 1'($urandom_range(0, 1));
      d = fixed ? 8'(17 * (sent + 1)) : 8'($urandom);
      x_valid_in = v;
      x_data_in  = d;
      if (v && x_ready_out) begin
        exp_x.push_back(d);
        sent++;
      end
      tick();
      guard++;
    end
    x_valid_in = 1'b0;
    xload_done = 1'b1;
    tick();
    xload_done = 1'b0;
    check("valid_input_count", 32'(n_xin - n0), 32'd4);
    check("alu_en_on_entry", ALU_en, 1'b1);
    check("ready_drops", x_ready_out, 1'b0);
  endtask

  task automatic compute(input int n_alu);
    int k;
    for (int i = 1; i <= n_alu; i++) begin
      if (i == n_alu) ALU_done = 1'b1;
      tick();
    end
    ALU_done = 1'b0;
    check("alu_en_off", ALU_en, 1'b0);
    k = 1;
    while (cs_n && k < 12) begin
      tick();
      k++;
    end
    check("cs_n_fall_delay", 32'(k), 32'(WB_LAT + 1));
  endtask

  // mode 0: ry always 1, mode 1: ry toggles 1,0,..., mode 2: random ry
  task automatic read_out(input int mode, input int stop_after);
    int pushed = 0;
    int guard = 0;
    logic tog = 1'b1;
    logic r;
    while (pushed < stop_after && guard < 200) begin
      check("cs_n_low_in_read", cs_n, 1'b0);
      case (mode)
        0:       r = 1'b1;
        1:       begin r = tog; tog = ~tog; end
        default: r = 1'($urandom_range(0, 1));
      endcase
      ry = r;
      read_data = 9'($urandom);
      if (r) begin
        exp_rd.push_back(read_data);
        pushed++;
      end
      tick();
      guard++;
    end
    ry = 1'b0;
  endtask

  task automatic full_run(input bit fixed, input int n_alu, input int mode);
    int d0 = n_done;
    int r0 = n_rd;
    do_start();
    load_x(fixed);
    compute(n_alu);
    read_out(mode, RD_WORDS);
    check("cs_n_high_after_last", cs_n, 1'b1);
    check("done_pulse", done, 1'b1);
    tick();
    check("done_one_cycle", done, 1'b0);
    check("idle_not_busy", busy, 1'b0);
    check("done_count", 32'(n_done - d0), 32'd1);
    check("beat_count", 32'(n_rd - r0), 32'(RD_WORDS));
    check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
  endtask

  initial begin
    int k;
    int d0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; x_valid_in = 1'b0; x_data_in = '0;
    xload_done = 1'b0; ALU_done = 1'b0; ry = 1'b0; read_data = '0;
    repeat (3) tick();
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_alu_en", ALU_en, 1'b0);
    check("rst_load_en", input_load_en, 1'b0);
    check("rst_ready", x_ready_out, 1'b0);
    check("rst_valid_input", valid_input, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_x_load", 32'(X_load), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_err", err_timeout, 1'b0);
    rst = 1'b0;
    tick();

    full_run(1'b1, 20, 0);
    full_run(1'b0, 5, 1);
    for (int i = 0; i < 3; i++) full_run(1'b0, int'($urandom_range(1, 10)), 2);

    // abort together with ALU_done: must return to IDLE, never reach DRAIN/READ
    d0 = n_done;
    do_start();
    load_x(1'b0);
    tick();
    ALU_done = 1'b1;
    abort = 1'b1;
    tick();
    ALU_done = 1'b0;
    abort = 1'b0;
    check("abort_alu_en", ALU_en, 1'b0);
    check("abort_busy", busy, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_read", cs_n, 1'b1);
    end
    check("abort_no_done", 32'(n_done - d0), 32'd0);

    // synchronous reset in the middle of the readout
    do_start();
    load_x(1'b0);
    compute(3);
    read_out(0, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_cs_n", cs_n, 1'b1);
    check("midrst_rd_valid", rd_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_queue", 32'(exp_rd.size()), 32'd0);
    tick();
    full_run(1'b0, 4, 0);

`ifdef MMUL_SEQ_WATCHDOG_EN
    do_start();
    k = 1;
    while (!err_timeout && k < TO_CYCLES + 20) begin
      tick();
      k++;
    end
    check("timeout_cycle", 32'(k >= TO_CYCLES && k <= TO_CYCLES + 1), 32'd1);
    check("err_set", err_timeout, 1'b1);
    check("err_not_busy", busy, 1'b0);
    check("err_load_en", input_load_en, 1'b0);
    check("err_cs_n", cs_n, 1'b1);
    tick();
    check("err_sticky", err_timeout, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err_cleared_by_start", err_timeout, 1'b0);
    check("err_restart_load", input_load_en, 1'b1);
`else
    do_start();
    k = 0;
    repeat (TO_CYCLES + 20) begin
      tick();
      k++;
    end
    check("no_watchdog_err", err_timeout, 1'b0);
    check("no_watchdog_still_load", input_load_en, 1'b1);
`endif
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("final_abort_idle", busy, 1'b0);
    check("final_abort_cs_n", cs_n, 1'b1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "global timeout");
  end

endmodule
